if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end. Consumer of the next-PC generator's output.
//  Holds the architectural PC and fetches one word from instruction memory
//  over a req/gnt + rvalid handshake. Presents the instruction to decode
//  over valid/ready, then waits for the next PC from the next-PC logic.
//  PC is word-addressed: sequential next PC is PC+1. One fetch outstanding max.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  ADDR_W    10             imem word-address width; imem_addr = pc[ADDR_W-1:0]
// PORTS
//  clk          in   1        clock, rising edge
//  rstn         in   1        asynchronous active-low reset
//  imem_req     out  1        fetch request, held until imem_gnt
//  imem_addr    out  ADDR_W   word address, stable while imem_req=1
//  imem_gnt     in   1        request accepted this cycle
//  imem_rvalid  in   1        imem_rdata valid this cycle
//  imem_rdata   in   32       fetched instruction
//  inst_valid   out  1        inst/inst_pc valid to decode
//  inst         out  32       instruction word
//  inst_pc      out  32       PC of inst
//  inst_ready   in   1        decode accepts inst this cycle
//  npc_we       in   1        npc_in valid; commit as next PC
//  npc_in       in   32       next PC from next-PC logic
//  fetch_cnt    out  32       count of instructions accepted by decode
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0,
//   inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0. Release is synchronous.
//  States:
//  - IDLE: next cycle -> REQ. Entered only from reset.
//  - REQ: imem_req=1, imem_addr=pc. On imem_gnt -> WAIT.
//  - WAIT: on imem_rvalid, register inst=imem_rdata, inst_pc=pc, and go to
//    VALID. imem_rvalid in the same cycle as imem_gnt is not legal for imem.
//  - VALID: inst_valid=1, and inst/inst_pc hold stable. On inst_ready,
//    fetch_cnt+=1 (wraps 2^32-1 -> 0) and inst_valid drops next cycle.
//    If npc_we is also 1 that cycle, load pc=npc_in and go -> REQ.
//    Otherwise go -> NEXT.
//  - NEXT: on npc_we, load pc=npc_in and go -> REQ.
//  Latency: gnt->inst_valid is 1 cycle after rvalid.
//   NEXT(npc_we)->imem_req is 1 cycle.
//  npc_we outside VALID(with inst_ready) or NEXT is ignored. pc is unchanged.
//  imem_rvalid outside WAIT is ignored. This covers a stale response after
//   reset mid-fetch.
//  npc_in is taken verbatim, all 32 bits. Addresses beyond ADDR_W are
//   truncated on imem_addr only; inst_pc keeps all 32 bits.
//  Reset asserted mid-operation in any state aborts at once.
//   No partial outputs persist.
// TESTING
//  1 Reset, release; gnt same cycle, rvalid 3 cycles later, rdata=32'h00500093
//    -> imem_addr=0, inst_valid 1 cycle after rvalid, inst_pc=0, inst=00500093.
//  2 Backpressure: inst_ready low 4 cycles then high
//    -> inst/inst_pc stable throughout; fetch_cnt 0->1 only on accept.
//  3 Sequential: npc_in=1 in NEXT, then npc_in=2 -> imem_addr 1 then 2.
//    Branch back, npc_in=32'h0000_0000 from pc 2 -> next imem_addr=0.
//  4 inst_ready and npc_we=1 same cycle, npc_in=32'h40
//    -> next cycle imem_req=1, imem_addr=10'h040, no NEXT cycle.
//  5 rstn low while in WAIT, release, stale rvalid rdata=32'hDEADBEEF
//    arrives in IDLE/REQ -> dropped; inst_valid stays 0; first fetch is RESET_PC.
//  6 Force fetch_cnt=32'hFFFF_FFFF, one accept -> fetch_cnt=0.
//    Spurious npc_we in WAIT -> pc unchanged.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid channel, decode
// valid/ready channel, next-PC write port and the accepted-instruction counter.
interface if_fetch_unit_if #(
   parameter int unsigned ADDR_W = 10
);
   localparam int unsigned DATA_W = 32;

   // instruction memory channel
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;

   // decode channel
   logic              inst_valid;
   logic [DATA_W-1:0] inst;
   logic [DATA_W-1:0] inst_pc;
   logic              inst_ready;

   // next-PC logic and status
   logic              npc_we;
   logic [DATA_W-1:0] npc_in;
   logic [DATA_W-1:0] fetch_cnt;

   // fetch unit side
   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc_we, npc_in
   );

   // environment side: memory, decode and next-PC logic
   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc_we, npc_in
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: holds the PC, performs one outstanding imem
// fetch at a time and hands the word to decode, then waits for the next PC.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rstn,
   if_fetch_unit_if.master   bus
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_VALID = 3'd3,
      S_NEXT  = 3'd4
   } state_e;

   state_e            state_q,      state_d;
   logic [DATA_W-1:0] pc_q,         pc_d;
   logic              imem_req_q,   imem_req_d;
   logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
   logic              inst_valid_q, inst_valid_d;
   logic [DATA_W-1:0] inst_q,       inst_d;
   logic [DATA_W-1:0] inst_pc_q,    inst_pc_d;
   logic [DATA_W-1:0] fetch_cnt_q,  fetch_cnt_d;

   // state and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   // next state; outputs are precomputed so they appear registered in the new state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      imem_req_d   = imem_req_q;
      imem_addr_d  = imem_addr_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      fetch_cnt_d  = fetch_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            state_d     = S_REQ;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q[ADDR_W-1:0];
         end

         S_REQ: begin
            if (bus.imem_gnt) begin
               state_d    = S_WAIT;
               imem_req_d = 1'b0;
            end
         end

         // responses are only honoured here, so stale data after a reset is dropped
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               state_d      = S_VALID;
               inst_valid_d = 1'b1;
               inst_d       = bus.imem_rdata;
               inst_pc_d    = pc_q;
            end
         end

         S_VALID: begin
            if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               fetch_cnt_d  = fetch_cnt_q + DATA_W'(1);
               if (bus.npc_we) begin
                  state_d     = S_REQ;
                  pc_d        = bus.npc_in;
                  imem_req_d  = 1'b1;
                  imem_addr_d = bus.npc_in[ADDR_W-1:0];
               end else begin
                  state_d = S_NEXT;
               end
            end
         end

         S_NEXT: begin
            if (bus.npc_we) begin
               state_d     = S_REQ;
               pc_d        = bus.npc_in;
               imem_req_d  = 1'b1;
               imem_addr_d = bus.npc_in[ADDR_W-1:0];
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: fetch responses and next-PC writes push
// expectations; decode accepts and imem requests pop and compare them.
module tb_if_fetch_unit;

   localparam int unsigned ADDR_W   = 10;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   if_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   if_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;
   exp_t        sb[$];
   logic [31:0] addr_exp[$];
   logic [31:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("req_timeout", 32'(bus.imem_req), 32'd1);
   endtask

   // serve one fetch: grant after gnt_dly cycles, respond rv_dly cycles after grant
   task automatic fetch(input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                        input bit spur);
      bit          ok;
      logic [31:0] pc;
      wait_req(ok);
      if (!ok) return;
      if (addr_exp.size() == 0) begin
         chk("addr_q_empty", 32'(addr_exp.size()), 32'd1);
         return;
      end
      pc = addr_exp.pop_front();
      chk("imem_addr", 32'(bus.imem_addr), 32'(pc[ADDR_W-1:0]));
      for (int i = 0; i < gnt_dly; i++) begin
         @(negedge clk);
         chk("req_held", 32'(bus.imem_req), 32'd1);
         chk("addr_held", 32'(bus.imem_addr), 32'(pc[ADDR_W-1:0]));
      end
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      chk("req_drop", 32'(bus.imem_req), 32'd0);
      for (int i = 1; i < rv_dly; i++) begin
         bus.npc_we = spur && (i == 1);
         bus.npc_in = 32'h0000_1234;
         @(negedge clk);
         bus.npc_we = 1'b0;
         chk("no_early_valid", 32'(bus.inst_valid), 32'd0);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = rdata;
      sb.push_back('{inst: rdata, pc: pc});
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      chk("valid_after_rvalid", 32'(bus.inst_valid), 32'd1);
   endtask

   // decode side: stall, then accept, optionally writing the next PC in the same cycle
   task automatic accept(input int stall, input bit with_npc, input logic [31:0] npc);
      exp_t e;
      bit   ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.inst_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("valid_wait", 32'(bus.inst_valid), 32'd1);
      if (!ok) return;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", 32'(bus.inst_valid), 32'd1);
         chk("stall_inst", bus.inst, e.inst);
         chk("stall_pc", bus.inst_pc, e.pc);
         chk("stall_cnt", bus.fetch_cnt, exp_cnt);
         @(negedge clk);
      end
      chk("inst", bus.inst, e.inst);
      chk("inst_pc", bus.inst_pc, e.pc);
      bus.inst_ready = 1'b1;
      if (with_npc) begin
         bus.npc_we = 1'b1;
         bus.npc_in = npc;
         addr_exp.push_back(npc);
      end
      @(negedge clk);
      bus.inst_ready = 1'b0;
      bus.npc_we     = 1'b0;
      exp_cnt++;
      chk("fetch_cnt", bus.fetch_cnt, exp_cnt);
      chk("valid_drop", 32'(bus.inst_valid), 32'd0);
      chk("req_after_accept", 32'(bus.imem_req), with_npc ? 32'd1 : 32'd0);
   endtask

   // next-PC write from NEXT after a couple of idle cycles
   task automatic next_pc(input logic [31:0] npc);
      repeat (2) begin
         @(negedge clk);
         chk("next_idle_req", 32'(bus.imem_req), 32'd0);
      end
      bus.npc_we = 1'b1;
      bus.npc_in = npc;
      addr_exp.push_back(npc);
      @(negedge clk);
      bus.npc_we = 1'b0;
      chk("npc_to_req", 32'(bus.imem_req), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit ok;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.inst_ready  = 1'b0;
      bus.npc_we      = 1'b0;
      bus.npc_in      = '0;

      repeat (2) @(negedge clk);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'd0);
      chk("rst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      chk("rst_cnt", bus.fetch_cnt, 32'd0);
      rstn = 1'b1;
      addr_exp.push_back(RESET_PC);

      // first fetch with backpressure
      fetch(32'h0050_0093, 0, 3, 1'b0);
      accept(4, 1'b0, '0);

      // sequential then branch back, spurious npc_we while waiting
      next_pc(32'd1);
      fetch(32'h1111_0001, 1, 1, 1'b0);
      accept(0, 1'b0, '0);
      next_pc(32'd2);
      fetch(32'h2222_0002, 0, 2, 1'b0);
      accept(1, 1'b0, '0);
      next_pc(32'd0);
      fetch(32'h3333_0003, 0, 3, 1'b1);

      // accept and next PC in the same cycle, then a truncated wide address
      accept(0, 1'b1, 32'h0000_0040);
      fetch(32'h4444_0004, 0, 1, 1'b0);
      accept(0, 1'b1, 32'h0001_0405);
      fetch(32'h5555_0005, 2, 1, 1'b0);

      // counter wrap on accept
      for (int i = 0; i < 20 && bus.inst_valid !== 1'b1; i++) @(negedge clk);
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      accept(0, 1'b0, '0);

      // reset while waiting for the response; stale response must be dropped
      next_pc(32'd7);
      wait_req(ok);
      if (ok) begin
         chk("pre_rst_addr", 32'(bus.imem_addr), 32'(addr_exp.pop_front()));
         bus.imem_gnt = 1'b1;
         @(negedge clk);
         bus.imem_gnt = 1'b0;
         rstn = 1'b0;
         #1;
         chk("midrst_req", 32'(bus.imem_req), 32'd0);
         chk("midrst_cnt", bus.fetch_cnt, 32'd0);
         chk("midrst_inst_pc", bus.inst_pc, 32'd0);
         @(negedge clk);
         rstn            = 1'b1;
         exp_cnt         = '0;
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 32'hDEAD_BEEF;
         addr_exp.push_back(RESET_PC);
         @(negedge clk);
         chk("stale_idle_valid", 32'(bus.inst_valid), 32'd0);
         chk("stale_req", 32'(bus.imem_req), 32'd1);
         @(negedge clk);
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
         chk("stale_req_valid", 32'(bus.inst_valid), 32'd0);
         chk("stale_inst", bus.inst, 32'd0);
         fetch(32'h6666_0006, 0, 1, 1'b0);
         accept(0, 1'b0, '0);
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("addr_drained", 32'(addr_exp.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
